// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and bit-period helper.
// Used by both uart_tx and uart_rx so the two ends always agree on line format.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bit length in system clocks; integer divide, remainder is dropped.
  function automatic int bit_timer_lim(input int clkfreq, input int baudrate);
    return clkfreq / baudrate;
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period counter: counts 0..c_lim-1 and flags the last clock of each bit.
// Held at zero while clr is high so the first bit after idle is full length.
module uart_baud_timer #(
  parameter int c_lim = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);

  localparam int CW = (c_lim > 1) ? $clog2(c_lim) : 1;

  if (c_lim < 1) begin : g_bad_lim
    $error("uart_baud_timer: c_lim must be at least 1");
  end

  logic [CW-1:0] cnt_reg;

  assign tc = (cnt_reg == CW'(c_lim - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || tc) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Every output comes straight from a flop, so the TX pin never glitches.
module uart_tx
  import uart_pkg::*;
#(
  parameter int c_clkfreq  = 100_000_000,
  parameter int c_baudrate = 115_200,
  parameter int c_parity   = 0,
  parameter int c_stopbits = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din_i,
  input  logic       tx_start_i,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_tick_o
);

  localparam int L = bit_timer_lim(c_clkfreq, c_baudrate);

  if (c_parity < PAR_NONE || c_parity > PAR_ODD) begin : g_bad_parity
    $error("uart_tx: c_parity must be 0 (none), 1 (even) or 2 (odd)");
  end
  if (c_stopbits < 1 || c_stopbits > 2) begin : g_bad_stopbits
    $error("uart_tx: c_stopbits must be 1 or 2");
  end

  state_t     state_reg;
  logic [7:0] data_reg;
  logic       par_reg;
  logic [2:0] idx_reg;
  logic       stop_idx_reg;
  logic       tx_reg;
  logic       busy_reg;
  logic       done_reg;
  logic       bit_tc;

  uart_baud_timer #(
    .c_lim(L)
  ) u_baud_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_reg == S_IDLE),
    .tc   (bit_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      data_reg     <= '0;
      par_reg      <= 1'b0;
      idx_reg      <= '0;
      stop_idx_reg <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          tx_reg <= 1'b1;
          if (tx_start_i) begin
            data_reg     <= din_i;
            par_reg      <= (c_parity == PAR_ODD) ? ~^din_i : ^din_i;
            idx_reg      <= '0;
            stop_idx_reg <= 1'b0;
            tx_reg       <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= S_START;
          end
        end
        S_START: begin
          if (bit_tc) begin
            tx_reg    <= data_reg[0];
            state_reg <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tc) begin
            if (idx_reg == 3'd7) begin
              // Parity slot only exists when a parity mode is configured.
              if (c_parity != PAR_NONE) begin
                tx_reg    <= par_reg;
                state_reg <= S_PARITY;
              end else begin
                tx_reg    <= 1'b1;
                state_reg <= S_STOP;
              end
            end else begin
              idx_reg <= idx_reg + 3'd1;
              tx_reg  <= data_reg[idx_reg + 3'd1];
            end
          end
        end
        S_PARITY: begin
          if (bit_tc) begin
            tx_reg    <= 1'b1;
            state_reg <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_tc) begin
            if (stop_idx_reg == 1'(c_stopbits - 1)) begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end else begin
              stop_idx_reg <= 1'b1;
            end
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_o           = tx_reg;
  assign tx_busy_o      = busy_reg;
  assign tx_done_tick_o = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four parameterisations, expected line levels
// built from the frame-format rules and compared clock by clock.
module tb_uart_tx;

  int lens  [4] = '{868, 10, 12, 868};
  int pars  [4] = '{0, 1, 2, 0};
  int stops [4] = '{1, 1, 2, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din [4];
  logic [3:0] start;
  logic [3:0] tx_w, busy_w, done_w;

  int unsigned cyc = 0;
  int n_tests = 0;
  int n_fail  = 0;

  logic exp_bits [16];
  int   exp_n;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx u_dut0 (
    .clk(clk), .rst_n(rst_n), .din_i(din[0]), .tx_start_i(start[0]),
    .tx_o(tx_w[0]), .tx_busy_o(busy_w[0]), .tx_done_tick_o(done_w[0])
  );
  uart_tx #(.c_clkfreq(1000), .c_baudrate(100), .c_parity(1), .c_stopbits(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din_i(din[1]), .tx_start_i(start[1]),
    .tx_o(tx_w[1]), .tx_busy_o(busy_w[1]), .tx_done_tick_o(done_w[1])
  );
  uart_tx #(.c_clkfreq(1200), .c_baudrate(100), .c_parity(2), .c_stopbits(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din_i(din[2]), .tx_start_i(start[2]),
    .tx_o(tx_w[2]), .tx_busy_o(busy_w[2]), .tx_done_tick_o(done_w[2])
  );
  uart_tx #(.c_parity(0), .c_stopbits(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .din_i(din[3]), .tx_start_i(start[3]),
    .tx_o(tx_w[3]), .tx_busy_o(busy_w[3]), .tx_done_tick_o(done_w[3])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Frame as a list of line levels, one entry per bit period.
  task automatic build_frame(input logic [7:0] d, input int par, input int nstop);
    int ones;
    exp_n = 0;
    exp_bits[exp_n++] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[exp_n++] = d[i];
    if (par != 0) begin
      ones = $countones(d);
      exp_bits[exp_n++] = (par == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    end
    for (int i = 0; i < nstop; i++) exp_bits[exp_n++] = 1'b1;
  endtask

  // Called at a negedge; the accept edge happens before the next negedge.
  task automatic send(input int sel, input logic [7:0] d, input bit hold);
    din[sel]   = d;
    start[sel] = 1'b1;
    @(negedge clk);
    if (!hold) start[sel] = 1'b0;
  endtask

  // Starts at the first cycle of a frame, ends at the negedge of the done-tick cycle.
  // poke_mode 1: mid-frame start pulse with a new din; 2: only change din.
  task automatic check_frame(input int sel, input logic [7:0] d, input int poke_mode,
                             input logic [7:0] poke_din, input string tag);
    int ok, nb, nd, idx, len;
    len = lens[sel];
    build_frame(d, pars[sel], stops[sel]);
    nb = 0;
    nd = 0;
    for (int k = 0; k < exp_n; k++) begin
      ok = 0;
      for (int c = 0; c < len; c++) begin
        idx = k * len + c;
        if (poke_mode != 0 && idx == 3 * len + 2) begin
          din[sel] = poke_din;
          if (poke_mode == 1) start[sel] = 1'b1;
        end else if (poke_mode == 1 && idx == 3 * len + 3) begin
          start[sel] = 1'b0;
        end
        if (tx_w[sel] === exp_bits[k]) ok++;
        if (busy_w[sel] !== 1'b1) nb++;
        if (done_w[sel] !== 1'b0) nd++;
        @(negedge clk);
      end
      check_eq($sformatf("%s_bit%0d", tag, k), ok, len);
    end
    check_eq({tag, "_busy"}, nb, 0);
    check_eq({tag, "_early_done"}, nd, 0);
    check_eq({tag, "_done"}, done_w[sel], 1);
    check_eq({tag, "_busy_end"}, busy_w[sel], 0);
    $display("[TB] %s: inst %0d byte 0x%02h, %0d bits of %0d clks", tag, sel, d, exp_n, len);
  endtask

  task automatic idle_check(input int sel, input int n, input string tag);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0 || done_w[sel] !== 1'b0) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] dq [4];
    int unsigned acc;
    int nd;

    rst_n = 1'b0;
    start = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx_w, 4'hF);
    check_eq("rst_busy", busy_w, 4'h0);
    check_eq("rst_done", done_w, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default parameters, 0xD2, latency from accept edge to done tick.
    send(0, 8'hD2, 1'b0);
    acc = cyc;
    check_frame(0, 8'hD2, 0, 8'h00, "t1_d2");
    check_eq("t1_latency", cyc + 1 - acc, 8681);
    idle_check(0, 4, "t1_idle");

    // Parity and stop-bit variants.
    send(1, 8'hD2, 1'b0);
    check_frame(1, 8'hD2, 0, 8'h00, "t3_even");
    send(2, 8'hD2, 1'b0);
    check_frame(2, 8'hD2, 0, 8'h00, "t3_odd");
    send(3, 8'hD2, 1'b0);
    check_frame(3, 8'hD2, 0, 8'h00, "t3_stop2");

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      @(negedge clk);
      send(1, d, 1'b0);
      check_frame(1, d, 0, 8'h00, $sformatf("rnd_even%0d", i));
      d = 8'($urandom_range(0, 255));
      @(negedge clk);
      send(2, d, 1'b0);
      check_frame(2, d, 0, 8'h00, $sformatf("rnd_odd%0d", i));
    end

    // Mid-frame start ignored; start in the done-tick cycle follows with no gap.
    @(negedge clk);
    send(1, 8'h55, 1'b0);
    check_frame(1, 8'h55, 1, 8'h0F, "t4_55");
    send(1, 8'hAA, 1'b0);
    check_frame(1, 8'hAA, 0, 8'h00, "t4_aa");
    idle_check(1, 30, "t4_idle");

    // Start held high for three frames, din moving mid-frame.
    for (int i = 0; i < 4; i++) dq[i] = 8'($urandom_range(0, 255));
    din[2]   = dq[0];
    start[2] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_frame(2, dq[k], 2, dq[k+1], $sformatf("t6_hold%0d", k));
      if (k < 2) @(negedge clk);
      else start[2] = 1'b0;
    end
    idle_check(2, 40, "t6_idle");

    // Asynchronous reset during data bit 3 (forced low so the jump to 1 is visible).
    d = 8'($urandom_range(0, 255)) & 8'hF7;
    send(0, d, 1'b0);
    repeat (4 * lens[0] + lens[0] / 2) @(negedge clk);
    check_eq("t5_bit3", tx_w[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_tx", tx_w[0], 1);
    check_eq("t5_rst_busy", busy_w[0], 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0) nd++;
    end
    check_eq("t5_no_done", nd, 0);
    rst_n = 1'b1;
    idle_check(0, 4, "t5_post_idle");
    send(0, 8'h3C, 1'b0);
    check_frame(0, 8'h3C, 0, 8'h00, "t5_3c");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
